// File: rtl/approx_sweep_checker_pkg.sv
// Shared types and width helpers for the approximate-circuit sweep checker.
// Statistic widths are derived from the stimulus and response widths of the circuit under evaluation.
package approx_eval_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_IN_W  = 4;
    localparam int DEF_OUT_W = 4;

    // A full sweep adds 2^IN_W errors of at most 2^OUT_W-1 each, so OUT_W+IN_W bits never overflow.
    function automatic int sum_w(input int in_w, input int out_w);
        return out_w + in_w;
    endfunction

    // Counts must reach 2^IN_W inclusive.
    function automatic int cnt_w(input int in_w);
        return in_w + 1;
    endfunction

    localparam int DEF_SUM_W = DEF_OUT_W + DEF_IN_W;
    localparam int DEF_CNT_W = DEF_IN_W + 1;

endpackage

// File: rtl/approx_sweep_checker_if.sv
// Stimulus/response and result bus between the sweep checker (master) and the evaluation harness (slave).
interface approx_sweep_checker_if #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 4
);
    logic                  start;
    logic [IN_W-1:0]       stim;
    logic                  stim_valid;
    logic [OUT_W-1:0]      exact_out;
    logic [OUT_W-1:0]      approx_out;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [OUT_W-1:0]      max_err;
    logic [OUT_W+IN_W-1:0] sum_err;
    logic [IN_W:0]         err_count;
    logic [IN_W:0]         fail_count;
    logic [IN_W-1:0]       first_fail_vec;
    logic                  first_fail_valid;

    modport master (
        input  start, exact_out, approx_out,
        output stim, stim_valid, busy, done, pass, max_err, sum_err,
               err_count, fail_count, first_fail_vec, first_fail_valid
    );

    modport slave (
        output start, exact_out, approx_out,
        input  stim, stim_valid, busy, done, pass, max_err, sum_err,
               err_count, fail_count, first_fail_vec, first_fail_valid
    );
endinterface

// File: rtl/approx_sweep_checker_err_accum.sv
// Error statistics for the sweep: absolute error per sample, running sum/max/counts and first failing vector.
// Accumulates on sample_en; clear restarts the statistics for a new sweep, rst takes priority.
module err_accum
    import approx_eval_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int OUT_W = 4,
    parameter int ET    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  sample_en,
    input  logic [IN_W-1:0]       tag,
    input  logic [OUT_W-1:0]      exact,
    input  logic [OUT_W-1:0]      approx,
    output logic [OUT_W-1:0]      max_err,
    output logic [OUT_W+IN_W-1:0] sum_err,
    output logic [IN_W:0]         err_count,
    output logic [IN_W:0]         fail_count,
    output logic [IN_W-1:0]       first_fail_vec,
    output logic                  first_fail_valid
);
    localparam int          SUM_W = sum_w(IN_W, OUT_W);
    localparam int          CNT_W = cnt_w(IN_W);
    localparam logic [31:0] ET_U  = ET;

    logic [OUT_W-1:0] err;
    logic             over;

    // Subtract in the direction that cannot borrow, so the magnitude fits in OUT_W bits.
    always_comb begin
        err = (exact >= approx) ? (exact - approx) : (approx - exact);
    end

    assign over = (32'(err) > ET_U);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            max_err          <= '0;
            sum_err          <= '0;
            err_count        <= '0;
            fail_count       <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else if (sample_en) begin
            sum_err <= sum_err + SUM_W'(err);
            if (err > max_err) begin
                max_err <= err;
            end
            if (err != '0) begin
                err_count <= err_count + CNT_W'(1);
            end
            if (over) begin
                fail_count <= fail_count + CNT_W'(1);
                if (!first_fail_valid) begin
                    first_fail_vec   <= tag;
                    first_fail_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/approx_sweep_checker.sv
// Exhaustive stimulus source and response sink for a combinational exact/approximate circuit pair.
// Presents one vector per cycle, samples responses LAT cycles later and reports error statistics on done.
module approx_sweep_checker
    import approx_eval_pkg::*;
#(
    parameter int IN_W         = DEF_IN_W,
    parameter int OUT_W        = DEF_OUT_W,
    parameter int ET           = 0,
    parameter int LAT          = 0,
    parameter int STOP_ON_FAIL = 0
) (
    input logic                    clk,
    input logic                    rst,
    approx_sweep_checker_if.master bus
);
    localparam logic [IN_W-1:0] LAST_VEC = '1;
    localparam logic [31:0]     ET_U     = ET;

    state_t                state;
    state_t                next_state;
    logic [IN_W-1:0]       stim;
    logic                  stim_valid;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic                  start_ok;
    logic                  halt;
    logic                  samp_vld;
    logic [IN_W-1:0]       samp_tag;
    logic                  pipe_busy;
    logic [OUT_W-1:0]      max_err;
    logic [OUT_W+IN_W-1:0] sum_err;
    logic [IN_W:0]         err_count;
    logic [IN_W:0]         fail_count;
    logic [IN_W-1:0]       ff_vec;
    logic                  ff_valid;

    assign start_ok = bus.start && ((state == IDLE) || (state == DONE));
    // Once the first failure is registered, the stop mode freezes statistics and ends the sweep.
    assign halt     = (STOP_ON_FAIL != 0) && ff_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (bus.start) next_state = SWEEP;
            SWEEP:   if ((stim == LAST_VEC) || halt) next_state = DRAIN;
            DRAIN:   if (!pipe_busy) next_state = DONE;
            DONE:    if (bus.start) next_state = SWEEP;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        stim_valid = (state == SWEEP);
        busy       = (state == SWEEP) || (state == DRAIN);
        done       = (state == DONE);
        pass       = done && (32'(max_err) <= ET_U);
    end

    // Counter runs only while the sweep continues; any other path parks it at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            stim <= '0;
        end else if ((state == SWEEP) && (next_state == SWEEP)) begin
            stim <= stim + IN_W'(1);
        end else begin
            stim <= '0;
        end
    end

    generate
        if (LAT == 0) begin : g_no_pipe
            assign samp_vld  = stim_valid;
            assign samp_tag  = stim;
            assign pipe_busy = 1'b0;
        end else begin : g_pipe
            logic [LAT-1:0]  vld_q;
            logic [IN_W-1:0] tag_q [LAT];

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q <= '0;
                    for (int i = 0; i < LAT; i++) begin
                        tag_q[i] <= '0;
                    end
                end else begin
                    vld_q[0] <= stim_valid;
                    tag_q[0] <= stim;
                    for (int i = 1; i < LAT; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        tag_q[i] <= tag_q[i-1];
                    end
                end
            end

            assign samp_vld  = vld_q[LAT-1];
            assign samp_tag  = tag_q[LAT-1];
            assign pipe_busy = |vld_q;
        end
    endgenerate

    err_accum #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .ET    (ET)
    ) u_err_accum (
        .clk              (clk),
        .rst              (rst),
        .clear            (start_ok),
        .sample_en        (samp_vld && !halt),
        .tag              (samp_tag),
        .exact            (bus.exact_out),
        .approx           (bus.approx_out),
        .max_err          (max_err),
        .sum_err          (sum_err),
        .err_count        (err_count),
        .fail_count       (fail_count),
        .first_fail_vec   (ff_vec),
        .first_fail_valid (ff_valid)
    );

    assign bus.stim             = stim;
    assign bus.stim_valid       = stim_valid;
    assign bus.busy             = busy;
    assign bus.done             = done;
    assign bus.pass             = pass;
    assign bus.max_err          = max_err;
    assign bus.sum_err          = sum_err;
    assign bus.err_count        = err_count;
    assign bus.fail_count       = fail_count;
    assign bus.first_fail_vec   = ff_vec;
    assign bus.first_fail_valid = ff_valid;

endmodule

// File: doc/approx_sweep_checker.md
Name: approx_sweep_checker

Overview:
- Sequential counterpart to the generated combinational approximate circuits (e.g. the 4-in/4-out approximate multipliers): drives their input bus and evaluates their output bus.
- Exhaustively sweeps all 2^IN_W input vectors, presenting each one to both the exact and the approximated netlist.
- Samples both responses and accumulates error statistics against the error threshold ET.
- Sits in the evaluation harness as the stimulus source and response sink for any in*/out* module of the flow.

Parameters:
- IN_W, 4, input vector width; stim bit i drives in<i>.
- OUT_W, 4, output width; bit i is out<i>; value interpreted as unsigned, out0 = LSB.
- ET, 0, error threshold; a vector fails when abs error > ET.
- LAT, 0, response latency in cycles between stim presentation and sampling (0..3).
- STOP_ON_FAIL, 0, when 1, abort the sweep on the first failing sample.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE.
- stim  out  IN_W  vector driven to both DUTs.
- stim_valid  out  1  high while stim carries a sweep vector.
- exact_out  in  OUT_W  exact circuit response.
- approx_out  in  OUT_W  approximated circuit response.
- busy  out  1  high in SWEEP and DRAIN.
- done  out  1  level, high in DONE.
- pass  out  1  valid when done; equals (max_err <= ET).
- max_err  out  OUT_W  largest abs error seen.
- sum_err  out  OUT_W+IN_W  sum of abs errors; cannot overflow by construction.
- err_count  out  IN_W+1  number of vectors with nonzero error.
- fail_count  out  IN_W+1  number of vectors with error > ET.
- first_fail_vec  out  IN_W  first vector whose error exceeded ET.
- first_fail_valid  out  1  first_fail_vec is meaningful.

Behaviour:
- Reset: all outputs 0, state IDLE. Reset mid-sweep aborts immediately with the same values. Reset has priority over start.
- States and transitions:
  - IDLE → SWEEP on start.
  - SWEEP → DRAIN after vector 2^IN_W-1 is presented, or on the first failing sample when STOP_ON_FAIL=1.
  - DRAIN → DONE once the LAT-deep tag pipeline is empty.
  - DONE → SWEEP on start.
- Accepting start (in IDLE or DONE) clears all statistics and first_fail_* in the same edge.
- Sweep and sampling:
  - Start accepted at edge k: stim=0 and stim_valid=1 from cycle k+1. stim increments by 1 each cycle up to 2^IN_W-1, then stim_valid=0 and stim returns to 0. No wrap.
  - The vector tag passes through a LAT-stage shift register. Responses for vector v are sampled at the edge LAT cycles after v is presented. With LAT=0 they are sampled in the cycle v is driven (combinational DUT).
- Arithmetic:
  - err = |exact_out - approx_out| computed on OUT_W-bit unsigned values; the result fits in OUT_W bits.
  - Per sample: sum_err += err. max_err = max(max_err, err). err_count += (err != 0). fail_count += (err > ET).
  - On the first sample with err > ET, set first_fail_vec = tag and first_fail_valid = 1.
  - err == ET is a pass.
- Timing: done rises at edge k+2^IN_W+LAT+1 for a full sweep; statistics are final when done rises.
- STOP_ON_FAIL=1: on the failing sample stim_valid drops next cycle, and the in-flight pipeline is drained but not accumulated. Counts therefore reflect vectors up to and including the first failure.
- start while busy is ignored; start in the same cycle as rst is ignored.
- stim_valid and busy are never high in DONE.

Decomposition:
- Package approx_eval_pkg holds:
  - state enum (IDLE, SWEEP, DRAIN, DONE);
  - width helper constants: SUM_W = OUT_W+IN_W, CNT_W = IN_W+1.
- One sub-module, err_accum: takes exact/approx/tag/sample_en/clear and holds all statistics registers.
- Top level: FSM, stim counter and tag pipeline.

Test Plan:
- Identical responses (approx_out tied to exact_out), defaults, start at edge k: done at edge k+17; pass=1; max_err=0; sum_err=0; err_count=0; fail_count=0; first_fail_valid=0.
- approx_out = exact_out ^ 1 only when stim=5, ET=0: pass=0; max_err=1; sum_err=1; err_count=1; fail_count=1; first_fail_vec=5.
- Same stimulus as the previous scenario with ET=1: pass=1; err_count=1; fail_count=0; first_fail_valid=0.
- exact_out=15, approx_out=0 at vectors 3 and 9, LAT=2 with responses delayed by 2 cycles: max_err=15; sum_err=30; fail_count=2; first_fail_vec=3; done at edge k+19.
- STOP_ON_FAIL=1 with the first failure at vector 6: stim_valid drops after vector 7 is driven; fail_count=1; err_count=1; done asserted; pass=0.
- rst asserted during the SWEEP cycle carrying stim=8: next cycle all outputs 0, IDLE; a start pulse mid-sweep is ignored; a fresh start after reset produces results identical to the first scenario.
